// File: rtl/fs_arb_pkg.sv
// Shared types and constants for the filesystem bridge arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fs_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWAP_HOLD,
        SYS_HOLD,
        SYS_REJECT
    } fs_state_e;

    typedef enum logic {
        REQ_SWAP,
        REQ_SYS
    } fs_req_e;

    localparam logic [7:0]  FS_SYSCALL_NONE  = 8'd0;
    localparam logic [31:0] FS_REJECT_RESULT = 32'hFFFF_FFFF;

    // Everything driven onto the HPS PIO exports; all-zero is the idle encoding.
    typedef struct packed {
        logic        swap_meta;
        logic        swap_rden;
        logic        swap_wren;
        logic [31:0] swap_address;
        logic [31:0] swap_data;
        logic [7:0]  syscall_id;
        logic [31:0] path_ptr1;
        logic [31:0] path_ptr2;
        logic [31:0] file_descriptor;
        logic [31:0] file_address;
        logic [31:0] write_data;
        logic [4:0]  file_bits;
    } fs_bridge_t;

endpackage

// File: rtl/fs_rr_arbiter.sv
// Two-requester grant select (swap vs syscall) with lastGrant tracking; FS_ROUND_ROBIN_EN alternates on contention.
// Latency: combinational select, lastGrant updates on the grant edge.
// Backpressure: a losing request stays pending at its level input; no queueing.
module fs_rr_arbiter
    import fs_arb_pkg::*;
(
    input  logic    CLOCK_50,
    input  logic    RESET_N,
    input  logic    swap_req,
    input  logic    sys_req,
    input  logic    grant_take,
    output logic    grant_vld,
    output fs_req_e grant_sel
);

    fs_req_e last_grant;

    assign grant_vld = swap_req | sys_req;

`ifdef FS_ROUND_ROBIN_EN
    always_comb begin
        grant_sel = swap_req ? REQ_SWAP : REQ_SYS;
        if (swap_req && sys_req) begin
            grant_sel = (last_grant == REQ_SYS) ? REQ_SWAP : REQ_SYS;
        end
    end
`else
    // Fixed priority: lastGrant is kept so both builds share one register map.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant_sel = swap_req ? REQ_SWAP : REQ_SYS;
`endif

    // Reset to SYS so swap wins the first contention.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            last_grant <= REQ_SYS;
        end else if (grant_take) begin
            last_grant <= grant_sel;
        end
    end

endmodule

// File: rtl/fs_request_arbiter.sv
// Shares the HPS filesystem PIO bridge between swap engine and syscall unit (FS_ROUND_ROBIN_EN selects alternation).
// Latency: grant at edge 0, ack in the cycle after edge HOLD_CYCLES; illegal syscall acked after edge 1.
// Backpressure: requests are levels held until ack; the loser waits in IDLE, at most one pending per requester.
module fs_request_arbiter
    import fs_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 64,
    parameter int CNT_W       = 16
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        swapReq,
    input  logic        swapMetaIn,
    input  logic        swapWrite,
    input  logic [31:0] swapAddressIn,
    input  logic [31:0] swapDataIn,
    output logic        swapAck,
    output logic [31:0] swapQOut,
    input  logic        sysReq,
    input  logic [7:0]  sysId,
    input  logic [31:0] sysPathPtr1,
    input  logic [31:0] sysPathPtr2,
    input  logic [31:0] sysFd,
    input  logic [31:0] sysAddr,
    input  logic [31:0] sysWriteData,
    input  logic [4:0]  sysBits,
    output logic        sysAck,
    output logic [31:0] sysResult,
    output logic        fsSwapMeta,
    output logic        fsSwapRden,
    output logic        fsSwapWren,
    output logic [31:0] fsSwapAddress,
    output logic [31:0] fsSwapData,
    input  logic [31:0] fsSwapQ,
    output logic [7:0]  fsSyscallId,
    output logic [31:0] fsPathPtr1,
    output logic [31:0] fsPathPtr2,
    output logic [31:0] fsFileDescriptor,
    output logic [31:0] fsFileAddress,
    output logic [31:0] fsWriteData,
    output logic [4:0]  fsFileBits,
    input  logic [31:0] fsDataOut,
    output logic        busy
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    fs_state_e        state, state_nxt;
    fs_bridge_t       bridge_q, bridge_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             grant_vld, grant_take;
    fs_req_e          grant_sel;
    logic             swap_done, sys_done, reject_done;

    fs_rr_arbiter u_arb (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .swap_req   (swapReq),
        .sys_req    (sysReq),
        .grant_take (grant_take),
        .grant_vld  (grant_vld),
        .grant_sel  (grant_sel)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            bridge_q <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            bridge_q <= bridge_nxt;
            cnt      <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bridge_nxt  = bridge_q;
        cnt_nxt     = cnt;
        grant_take  = 1'b0;
        swap_done   = 1'b0;
        sys_done    = 1'b0;
        reject_done = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    grant_take = 1'b1;
                    cnt_nxt    = '0;
                    if (grant_sel == REQ_SWAP) begin
                        state_nxt               = SWAP_HOLD;
                        bridge_nxt              = '0;
                        bridge_nxt.swap_meta    = swapMetaIn;
                        bridge_nxt.swap_rden    = !swapWrite;
                        bridge_nxt.swap_wren    = swapWrite;
                        bridge_nxt.swap_address = swapAddressIn;
                        bridge_nxt.swap_data    = swapDataIn;
                    end else if (sysId == FS_SYSCALL_NONE) begin
                        // Illegal id never reaches the bridge.
                        state_nxt = SYS_REJECT;
                    end else begin
                        state_nxt                  = SYS_HOLD;
                        bridge_nxt                 = '0;
                        bridge_nxt.syscall_id      = sysId;
                        bridge_nxt.path_ptr1       = sysPathPtr1;
                        bridge_nxt.path_ptr2       = sysPathPtr2;
                        bridge_nxt.file_descriptor = sysFd;
                        bridge_nxt.file_address    = sysAddr;
                        bridge_nxt.write_data      = sysWriteData;
                        bridge_nxt.file_bits       = sysBits;
                    end
                end
            end
            SWAP_HOLD, SYS_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt  = IDLE;
                    bridge_nxt = '0;
                    swap_done  = (state == SWAP_HOLD);
                    sys_done   = (state == SYS_HOLD);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SYS_REJECT: begin
                state_nxt   = IDLE;
                reject_done = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results are sampled on the completion edge and held until the next completion.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            swapAck   <= 1'b0;
            sysAck    <= 1'b0;
            swapQOut  <= '0;
            sysResult <= '0;
        end else begin
            swapAck <= swap_done;
            sysAck  <= sys_done | reject_done;
            if (swap_done) begin
                swapQOut <= fsSwapQ;
            end
            if (sys_done) begin
                sysResult <= fsDataOut;
            end else if (reject_done) begin
                sysResult <= FS_REJECT_RESULT;
            end
        end
    end

    assign fsSwapMeta       = bridge_q.swap_meta;
    assign fsSwapRden       = bridge_q.swap_rden;
    assign fsSwapWren       = bridge_q.swap_wren;
    assign fsSwapAddress    = bridge_q.swap_address;
    assign fsSwapData       = bridge_q.swap_data;
    assign fsSyscallId      = bridge_q.syscall_id;
    assign fsPathPtr1       = bridge_q.path_ptr1;
    assign fsPathPtr2       = bridge_q.path_ptr2;
    assign fsFileDescriptor = bridge_q.file_descriptor;
    assign fsFileAddress    = bridge_q.file_address;
    assign fsWriteData      = bridge_q.write_data;
    assign fsFileBits       = bridge_q.file_bits;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_fs_request_arbiter.sv
// Directed bench for fs_request_arbiter with HOLD_CYCLES=4.
// Contention expectations follow FS_ROUND_ROBIN_EN when it is defined for the build.
module tb_fs_request_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N;
    logic        swapReq, swapMetaIn, swapWrite;
    logic [31:0] swapAddressIn, swapDataIn;
    logic        swapAck;
    logic [31:0] swapQOut;
    logic        sysReq;
    logic [7:0]  sysId;
    logic [31:0] sysPathPtr1, sysPathPtr2, sysFd, sysAddr, sysWriteData;
    logic [4:0]  sysBits;
    logic        sysAck;
    logic [31:0] sysResult;
    logic        fsSwapMeta, fsSwapRden, fsSwapWren;
    logic [31:0] fsSwapAddress, fsSwapData, fsSwapQ;
    logic [7:0]  fsSyscallId;
    logic [31:0] fsPathPtr1, fsPathPtr2, fsFileDescriptor, fsFileAddress, fsWriteData;
    logic [4:0]  fsFileBits;
    logic [31:0] fsDataOut;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    fs_request_arbiter #(.HOLD_CYCLES(4), .CNT_W(16)) dut (
        .CLOCK_50         (CLOCK_50),
        .RESET_N          (RESET_N),
        .swapReq          (swapReq),
        .swapMetaIn       (swapMetaIn),
        .swapWrite        (swapWrite),
        .swapAddressIn    (swapAddressIn),
        .swapDataIn       (swapDataIn),
        .swapAck          (swapAck),
        .swapQOut         (swapQOut),
        .sysReq           (sysReq),
        .sysId            (sysId),
        .sysPathPtr1      (sysPathPtr1),
        .sysPathPtr2      (sysPathPtr2),
        .sysFd            (sysFd),
        .sysAddr          (sysAddr),
        .sysWriteData     (sysWriteData),
        .sysBits          (sysBits),
        .sysAck           (sysAck),
        .sysResult        (sysResult),
        .fsSwapMeta       (fsSwapMeta),
        .fsSwapRden       (fsSwapRden),
        .fsSwapWren       (fsSwapWren),
        .fsSwapAddress    (fsSwapAddress),
        .fsSwapData       (fsSwapData),
        .fsSwapQ          (fsSwapQ),
        .fsSyscallId      (fsSyscallId),
        .fsPathPtr1       (fsPathPtr1),
        .fsPathPtr2       (fsPathPtr2),
        .fsFileDescriptor (fsFileDescriptor),
        .fsFileAddress    (fsFileAddress),
        .fsWriteData      (fsWriteData),
        .fsFileBits       (fsFileBits),
        .fsDataOut        (fsDataOut),
        .busy             (busy)
    );

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic exp_swap [4];
    logic drop_swap [4];

    initial begin
        RESET_N = 1'b0;
        swapReq = 0; swapMetaIn = 0; swapWrite = 0; swapAddressIn = '0; swapDataIn = '0;
        sysReq = 0; sysId = '0; sysPathPtr1 = '0; sysPathPtr2 = '0; sysFd = '0;
        sysAddr = '0; sysWriteData = '0; sysBits = '0;
        fsSwapQ = 32'h1111_1111; fsDataOut = '0;
`ifdef FS_ROUND_ROBIN_EN
        exp_swap  = '{1'b1, 1'b0, 1'b1, 1'b0};
        drop_swap = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_swap  = '{1'b1, 1'b1, 1'b0, 1'b0};
        drop_swap = '{1'b0, 1'b1, 1'b0, 1'b0};
`endif

        // Reset state
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_swapAck", {31'd0, swapAck}, 32'd0);
        check("rst_sysAck", {31'd0, sysAck}, 32'd0);
        check("rst_rden", {31'd0, fsSwapRden}, 32'd0);
        check("rst_sysid", {24'd0, fsSyscallId}, 32'd0);
        RESET_N = 1'b1;
        tick();

        // Swap read
        swapReq = 1; swapWrite = 0; swapMetaIn = 1; swapAddressIn = 32'h100; swapDataIn = 32'h55;
        tick();
        check("swp_rden_e0", {31'd0, fsSwapRden}, 32'd1);
        check("swp_wren_e0", {31'd0, fsSwapWren}, 32'd0);
        check("swp_meta_e0", {31'd0, fsSwapMeta}, 32'd1);
        check("swp_addr_e0", fsSwapAddress, 32'h100);
        check("swp_busy_e0", {31'd0, busy}, 32'd1);
        check("swp_sysid_e0", {24'd0, fsSyscallId}, 32'd0);
        for (int e = 1; e <= 3; e++) begin
            if (e == 2) fsSwapQ = 32'hDEAD_BEEF;
            tick();
            check("swp_rden_hold", {31'd0, fsSwapRden}, 32'd1);
            check("swp_ack_early", {31'd0, swapAck}, 32'd0);
        end
        tick();
        check("swp_ack", {31'd0, swapAck}, 32'd1);
        check("swp_q", swapQOut, 32'hDEAD_BEEF);
        check("swp_rden_idle", {31'd0, fsSwapRden}, 32'd0);
        check("swp_addr_idle", fsSwapAddress, 32'd0);
        check("swp_busy_idle", {31'd0, busy}, 32'd0);
        swapReq = 0;
        fsSwapQ = 32'h0;
        tick();
        check("swp_ack_pulse", {31'd0, swapAck}, 32'd0);
        check("swp_q_held", swapQOut, 32'hDEAD_BEEF);
        check("swp_no_regrant", {31'd0, busy}, 32'd0);

        // Syscall
        sysReq = 1; sysId = 8'd3; sysFd = 32'd7; sysPathPtr1 = 32'hA0; sysBits = 5'd9; fsDataOut = 32'd42;
        tick();
        check("sys_id_e0", {24'd0, fsSyscallId}, 32'd3);
        check("sys_fd_e0", fsFileDescriptor, 32'd7);
        check("sys_p1_e0", fsPathPtr1, 32'hA0);
        check("sys_bits_e0", {27'd0, fsFileBits}, 32'd9);
        check("sys_rden_e0", {31'd0, fsSwapRden}, 32'd0);
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("sys_id_hold", {24'd0, fsSyscallId}, 32'd3);
            check("sys_ack_early", {31'd0, sysAck}, 32'd0);
        end
        tick();
        check("sys_ack", {31'd0, sysAck}, 32'd1);
        check("sys_result", sysResult, 32'd42);
        check("sys_id_idle", {24'd0, fsSyscallId}, 32'd0);
        check("sys_fd_idle", fsFileDescriptor, 32'd0);
        sysReq = 0;
        tick();
        check("sys_ack_pulse", {31'd0, sysAck}, 32'd0);
        check("sys_result_held", sysResult, 32'd42);

        // Illegal syscall id
        sysReq = 1; sysId = 8'd0; sysPathPtr1 = 32'hABC;
        tick();
        check("rej_busy", {31'd0, busy}, 32'd1);
        check("rej_sysid", {24'd0, fsSyscallId}, 32'd0);
        check("rej_p1", fsPathPtr1, 32'd0);
        check("rej_ack_early", {31'd0, sysAck}, 32'd0);
        tick();
        check("rej_ack", {31'd0, sysAck}, 32'd1);
        check("rej_result", sysResult, 32'hFFFF_FFFF);
        check("rej_p1_idle", fsPathPtr1, 32'd0);
        sysReq = 0;
        tick();
        check("rej_ack_pulse", {31'd0, sysAck}, 32'd0);
        check("rej_busy_idle", {31'd0, busy}, 32'd0);

        // Contention, requests held across rounds
        swapReq = 1; swapWrite = 1; swapAddressIn = 32'h200;
        sysReq = 1; sysId = 8'd5;
        for (int r = 0; r < 4; r++) begin
            tick();
            check("arb_swap_grant", {31'd0, fsSwapWren}, {31'd0, exp_swap[r]});
            check("arb_sys_grant", {24'd0, fsSyscallId}, exp_swap[r] ? 32'd0 : 32'd5);
            tick(); tick(); tick();
            tick();
            check("arb_swapAck", {31'd0, swapAck}, {31'd0, exp_swap[r]});
            check("arb_sysAck", {31'd0, sysAck}, {31'd0, !exp_swap[r]});
            check("arb_gap_wren", {31'd0, fsSwapWren}, 32'd0);
            check("arb_gap_sysid", {24'd0, fsSyscallId}, 32'd0);
            if (drop_swap[r]) swapReq = 0;
        end
        swapReq = 0; sysReq = 0;
        tick();
        check("arb_end_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a hold
        swapReq = 1; swapWrite = 0; swapAddressIn = 32'h300;
        tick(); tick(); tick();
        check("mid_rden_pre", {31'd0, fsSwapRden}, 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        check("mid_rden_async", {31'd0, fsSwapRden}, 32'd0);
        check("mid_addr_async", fsSwapAddress, 32'd0);
        check("mid_busy_async", {31'd0, busy}, 32'd0);
        tick();
        check("mid_ack_none", {31'd0, swapAck}, 32'd0);
        RESET_N = 1'b1;
        tick();
        check("mid_regrant", {31'd0, fsSwapRden}, 32'd1);
        check("mid_regrant_addr", fsSwapAddress, 32'h300);
        tick(); tick(); tick();
        check("mid_full_hold", {31'd0, swapAck}, 32'd0);
        swapReq = 0;
        tick();
        check("mid_ack", {31'd0, swapAck}, 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fs_request_arbiter.md
Name: fs_request_arbiter

Overview:
- Sequences and shares the HPS filesystem bridge between two requesters: the page-swap engine (swap read/write, meta or data space) and the CPU syscall unit.
- The bridge is a set of PIO exports polled by HPS software and has no handshake of its own.
- This block grants one requester at a time and holds the command stable for a fixed window. It then captures the result, pulses an ack, and returns the bridge to its idle encoding.
- It sits between the CPU/MMU and the filesystem module; all bridge inputs come only from this block.

Parameters:
- HOLD_CYCLES, 64, clock cycles a command is held on the bridge before the result is sampled; legal range 2..65535.
- CNT_W, 16, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- CLOCK_50  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- swapReq  in  1  swap request, level, held until swapAck
- swapMetaIn  in  1  1 = metadata space, 0 = data space
- swapWrite  in  1  1 = write, 0 = read
- swapAddressIn  in  32  swap word address
- swapDataIn  in  32  swap write data
- swapAck  out  1  one-cycle completion pulse
- swapQOut  out  32  swap read result, valid while swapAck=1, held afterwards
- sysReq  in  1  syscall request, level, held until sysAck
- sysId  in  8  syscall id; 0 is illegal
- sysPathPtr1, sysPathPtr2, sysFd, sysAddr, sysWriteData  in  32 each  syscall operands
- sysBits  in  5  file read width
- sysAck  out  1  one-cycle completion pulse
- sysResult  out  32  syscall result, valid while sysAck=1, held afterwards
- fsSwapMeta, fsSwapRden, fsSwapWren  out  1 each  bridge swap controls
- fsSwapAddress, fsSwapData  out  32 each  bridge swap operands
- fsSwapQ  in  32  bridge swap read data
- fsSyscallId  out  8  bridge syscall id; 0 = none
- fsPathPtr1, fsPathPtr2, fsFileDescriptor, fsFileAddress, fsWriteData  out  32 each  bridge syscall operands
- fsFileBits  out  5  bridge file read width
- fsDataOut  in  32  bridge syscall result
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, hold counter 0, lastGrant = SYS so that swap wins the first contention. Reset mid-transaction drops it immediately with no ack; the requester re-requests.
- State machine: IDLE -> SWAP_HOLD or SYS_HOLD -> IDLE. An illegal syscall takes IDLE -> SYS_REJECT -> IDLE.
- IDLE:
  - Sample swapReq and sysReq; select a winner per the arbitration rule.
  - At the grant edge (edge 0), latch the winner's payload into registered bridge outputs and clear the counter.
  - Swap grant: fsSwapRden = !swapWrite, fsSwapWren = swapWrite.
  - Syscall grant: fsSyscallId = sysId.
- HOLD:
  - Bridge outputs stay constant and the counter increments each cycle.
  - At edge HOLD_CYCLES, capture fsSwapQ into swapQOut (swap) or fsDataOut into sysResult (syscall).
  - At the same edge, assert the matching ack for exactly one cycle and return to IDLE.
  - Also at that edge, force all fs* outputs to 0: rden = wren = 0, fsSyscallId = 0.
- Latency: a request sampled at edge 0 is acked in the cycle following edge HOLD_CYCLES.
- Idle gap: a new grant is made no earlier than the edge after ack. This guarantees at least one idle-encoded cycle between commands so HPS software can detect edges.
- Illegal syscall id: sysReq with sysId == 0 goes to SYS_REJECT. No bridge drive; the next cycle gives sysAck = 1 and sysResult = 32'hFFFF_FFFF.
- Arbitration with only one request pending: that requester is granted.
- Arbitration with both pending: without FS_ROUND_ROBIN_EN, swap always wins. lastGrant updates on every grant.
- Requester protocol:
  - Payload must be stable from req rise to ack.
  - req low during the ack cycle ends the request; req still high in the cycle after ack is a new request.
  - If req drops after grant, the transaction still completes and ack is still pulsed.
  - A requester's req while the other holds the bridge waits; no queueing depth beyond the pending level request.
- Outputs toward the requesters are never combinational from inputs; all fs* outputs are registered.

Optional Feature:
- Macro: FS_ROUND_ROBIN_EN.
- Defined: when both requests are pending in IDLE, the requester not in lastGrant wins, so contention alternates swap, sys, swap, ...
- Undefined: fixed priority, swap over syscall. lastGrant is still maintained but unused.

Decomposition:
- Package fs_arb_pkg holds:
  - state enum {IDLE, SWAP_HOLD, SYS_HOLD, SYS_REJECT}
  - requester enum {REQ_SWAP, REQ_SYS}
  - FS_SYSCALL_NONE = 8'd0
  - FS_REJECT_RESULT = 32'hFFFF_FFFF
- One sub-module, fs_rr_arbiter: 2-input grant logic with the lastGrant register and the FS_ROUND_ROBIN_EN selection. The top holds the FSM, counter, payload/result registers.

Test Plan:
- Swap read: HOLD_CYCLES=4, swapReq with swapWrite=0, addr 32'h100, fsSwapQ=32'hDEADBEEF -> fsSwapRden=1 for edges 0..3, swapAck in the cycle after edge 4, swapQOut=32'hDEADBEEF, rden back to 0.
- Syscall: sysId=8'd3, sysFd=7, fsDataOut=32'd42 -> fsSyscallId=3 and fsFileDescriptor=7 held for 4 cycles, sysAck pulse with sysResult=42, fsSyscallId=0 afterwards.
- Simultaneous requests, two rounds each with requests held:
  - Without FS_ROUND_ROBIN_EN: order swap, swap, then sys once swap drops.
  - With FS_ROUND_ROBIN_EN: order swap, sys, swap, sys.
  - At least one idle cycle between grants in both cases.
- Illegal id: sysReq with sysId=0 -> no fs* change, sysAck in the second cycle, sysResult=32'hFFFFFFFF.
- Reset mid-hold: RESET_N low at counter=2 -> all fs* outputs 0 asynchronously, no ack, busy=0; after release, a held swapReq is re-granted from edge 0.
